// File: rtl/pingpong_pkg.sv
// Shared definitions for the paddle-location serial receive path.
// Provides location/coordinate widths, the default frame sync byte,
// the frame and byte-receiver state encodings, and the frame checksum.
package pingpong_pkg;

  localparam int LOC_W   = 22;
  localparam int COORD_W = 11;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_GET_B0,
    ST_GET_B1,
    ST_GET_B2,
    ST_GET_CK
  } frame_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver, LSB first.
// Ports:
//   clk, rst_n    - system clock, synchronous active-low reset
//   uart_rx       - asynchronous serial line, idles high
//   byte_valid    - 1-clk pulse, byte_data holds a byte with a good stop bit
//   byte_data     - last received byte
//   byte_ferr     - 1-clk pulse, stop bit was sampled low
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a low (start) level
// RX_START     | counting to the middle of the start bit
// RX_DATA      | sampling 8 data bits at bit centres
// RX_STOP      | sampling the stop bit
// RX_WAIT_HIGH | byte done, waiting for the line to return high
module uart_byte_rx
  import pingpong_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_sync;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_d, ferr_d;

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      byte_ferr  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        // Only reached with the line high, so a low level is a falling edge.
        if (!rx_sync) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rx_sync) begin
            state_d = RX_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          if (rx_sync) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
          state_d = RX_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/pat_frame_rx.sv
// Paddle-location frame receiver: HEADER, B0, B1, B2, CK over UART.
// Ports:
//   clk, rst_n    - system clock, synchronous active-low reset
//   uart_rx       - serial line from the sensor MCU
//   pat_location  - last accepted location {x[10:0], y[10:0]}
//   pat_valid     - 1-clk pulse when pat_location was just updated
//   frame_err     - 1-clk pulse on a rejected frame, bad stop bit or timeout
//   link_up       - high from the first accepted frame until reset
//
// state     | meaning
// ST_HUNT   | waiting for the HEADER byte, other bytes dropped
// ST_GET_B0 | waiting for B0 = {2'b00, loc[21:16]}
// ST_GET_B1 | waiting for B1 = loc[15:8]
// ST_GET_B2 | waiting for B2 = loc[7:0]
// ST_GET_CK | waiting for CK, then accept or reject the frame
module pat_frame_rx
  import pingpong_pkg::*;
#(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         BAUD         = 9600,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER,
  parameter int         TIMEOUT_CLKS = 20 * (CLK_FREQ / BAUD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx,
  output logic [LOC_W-1:0] pat_location,
  output logic             pat_valid,
  output logic             frame_err,
  output logic             link_up
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(TIMEOUT_CLKS);

  logic       byte_valid, byte_ferr;
  logic [7:0] byte_data;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ferr (byte_ferr)
  );

  frame_state_t     state_q, state_d;
  logic [7:0]       b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [TW-1:0]    gap_q, gap_d;
  logic [LOC_W-1:0] loc_q, loc_d;
  logic             pv_q, pv_d, fe_q, fe_d, link_q, link_d;
  logic             ck_ok;

  assign ck_ok = (byte_data == frame_checksum(b0_q, b1_q, b2_q)) && (b0_q[7:6] == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      gap_q   <= '0;
      loc_q   <= '0;
      pv_q    <= 1'b0;
      fe_q    <= 1'b0;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      gap_q   <= gap_d;
      loc_q   <= loc_d;
      pv_q    <= pv_d;
      fe_q    <= fe_d;
      link_q  <= link_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    gap_d   = gap_q;
    loc_d   = loc_q;
    pv_d    = 1'b0;
    fe_d    = 1'b0;
    link_d  = link_q;
    if (byte_ferr) begin
      fe_d    = 1'b1;
      state_d = ST_HUNT;
    end else if (byte_valid) begin
      // A byte always reloads the gap timer, so it wins over a same-cycle timeout.
      gap_d = GAP_LOAD;
      case (state_q)
        ST_HUNT:   if (byte_data == HEADER) state_d = ST_GET_B0;
        ST_GET_B0: begin b0_d = byte_data; state_d = ST_GET_B1; end
        ST_GET_B1: begin b1_d = byte_data; state_d = ST_GET_B2; end
        ST_GET_B2: begin b2_d = byte_data; state_d = ST_GET_CK; end
        ST_GET_CK: begin
          if (ck_ok) begin
            loc_d  = {b0_q[5:0], b1_q, b2_q};
            pv_d   = 1'b1;
            link_d = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (state_q != ST_HUNT) begin
      if (gap_q == '0) begin
        fe_d    = 1'b1;
        state_d = ST_HUNT;
      end else begin
        gap_d = gap_q - TW'(1);
      end
    end
  end

  assign pat_location = loc_q;
  assign pat_valid    = pv_q;
  assign frame_err    = fe_q;
  assign link_up      = link_q;

endmodule

// File: tb/tb_pat_frame_rx.sv
// Self-checking bench for pat_frame_rx: directed frame table, multi-cycle
// corner sequences, and random frame streams against a frame-level model.
module tb_pat_frame_rx;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int TMO      = 20 * CPB;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [21:0] pat_location;
  logic        pat_valid, frame_err, link_up;

  pat_frame_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .HEADER  (HDR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .pat_location(pat_location),
    .pat_valid   (pat_valid),
    .frame_err   (frame_err),
    .link_up     (link_up)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pv_cnt   = 0;
  int fe_cnt   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pulse monitor: counts pulses and checks pulse shape / location stability.
  logic        prev_pv = 1'b0, prev_fe = 1'b0;
  logic [21:0] prev_loc = '0;
  logic [1:0]  rst_hist = 2'b00;
  always @(negedge clk) begin
    if (pat_valid) pv_cnt++;
    if (frame_err) fe_cnt++;
    if (pat_valid || frame_err) check("pulse_exclusive", {31'b0, pat_valid & frame_err}, 0);
    if (pat_valid) check("pv_one_cycle", {31'b0, prev_pv}, 0);
    if (frame_err) check("fe_one_cycle", {31'b0, prev_fe}, 0);
    if (pat_location != prev_loc && rst_n && (&rst_hist))
      check("loc_only_with_pv", {31'b0, pat_valid}, 1);
    prev_pv  = pat_valid;
    prev_fe  = frame_err;
    prev_loc = pat_location;
    rst_hist = {rst_hist[0], rst_n};
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CPB);
    end
    uart_rx = stop;
    wait_clks(CPB);
    uart_rx = 1'b1;
    if (!stop) wait_clks(CPB);
  endtask

  task automatic send_frame(input logic [21:0] loc);
    logic [7:0] b0, b1, b2;
    b0 = {2'b00, loc[21:16]};
    b1 = loc[15:8];
    b2 = loc[7:0];
    send_byte(HDR, 1'b1);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b0 ^ b1 ^ b2, 1'b1);
  endtask

  task automatic clear_counts();
    pv_cnt = 0;
    fe_cnt = 0;
  endtask

  // Directed table
  typedef struct {
    logic [5:0][7:0] bytes;
    int              nb;
    int              exp_pv;
    int              exp_fe;
    logic [21:0]     exp_loc;
    logic            exp_link;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [7:0] a0, a1, a2, a3, a4, a5,
                              input int nb, pv, fe, input logic [21:0] loc,
                              input logic link);
    vec_t v;
    v.bytes    = {a5, a4, a3, a2, a1, a0};
    v.nb       = nb;
    v.exp_pv   = pv;
    v.exp_fe   = fe;
    v.exp_loc  = loc;
    v.exp_link = link;
    return v;
  endfunction

  // Frame-level reference model state
  logic [7:0]  stream[$];
  logic [21:0] m_loc  = '0;
  logic        m_link = 1'b0;
  int          e_pv, e_fe;

  // Scan a byte stream the way the frame rules describe: hunt for the sync
  // byte, take the next four bytes as a frame, accept if checksum and
  // reserved bits agree.
  task automatic model_stream();
    int i;
    logic [7:0] b0, b1, b2, ck;
    e_pv = 0;
    e_fe = 0;
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] == HDR && i + 4 < stream.size()) begin
        b0 = stream[i+1]; b1 = stream[i+2]; b2 = stream[i+3]; ck = stream[i+4];
        if ((b0 ^ b1 ^ b2) == ck && b0[7:6] == 2'b00) begin
          e_pv++;
          m_loc  = {b0[5:0], b1, b2};
          m_link = 1'b1;
        end else begin
          e_fe++;
        end
        i += 5;
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    logic [7:0]  b0, b1, b2, ck;
    logic [21:0] rloc;
    int          kind;

    vecs[0] = mk(8'hA5, 8'h06, 8'h44, 8'h4C, 8'h0F, 8'h00, 5, 0, 1, 22'h000000, 1'b0);
    vecs[1] = mk(8'hA5, 8'h06, 8'h44, 8'h4C, 8'h0E, 8'h00, 5, 1, 0, 22'h06444C, 1'b1);
    vecs[2] = mk(8'h3C, 8'hA5, 8'h12, 8'h34, 8'h56, 8'h70, 6, 1, 0, 22'h123456, 1'b1);
    vecs[3] = mk(8'hA5, 8'h46, 8'h00, 8'h00, 8'h46, 8'h00, 5, 0, 1, 22'h123456, 1'b1);
    vecs[4] = mk(8'hA5, 8'h3F, 8'hFF, 8'hFF, 8'h3F, 8'h00, 5, 1, 0, 22'h3FFFFF, 1'b1);
    vecs[5] = mk(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 5, 1, 0, 22'h000000, 1'b1);

    // Reset state
    rst_n = 1'b0;
    wait_clks(5);
    check("reset_loc",   {10'b0, pat_location}, 0);
    check("reset_pv",    {31'b0, pat_valid}, 0);
    check("reset_fe",    {31'b0, frame_err}, 0);
    check("reset_link",  {31'b0, link_up}, 0);
    rst_n = 1'b1;
    wait_clks(5);

    // Directed table
    for (int k = 0; k < 6; k++) begin
      clear_counts();
      for (int j = 0; j < vecs[k].nb; j++) send_byte(vecs[k].bytes[j], 1'b1);
      wait_clks(10);
      check($sformatf("vec%0d_pv", k),   pv_cnt, vecs[k].exp_pv);
      check($sformatf("vec%0d_fe", k),   fe_cnt, vecs[k].exp_fe);
      check($sformatf("vec%0d_loc", k),  {10'b0, pat_location}, {10'b0, vecs[k].exp_loc});
      check($sformatf("vec%0d_link", k), {31'b0, link_up}, {31'b0, vecs[k].exp_link});
    end
    m_loc  = 22'h000000;
    m_link = 1'b1;

    // Timeout mid-frame, then a valid frame
    clear_counts();
    send_byte(HDR, 1'b1);
    send_byte(8'h06, 1'b1);
    wait_clks(TMO + 60);
    check("timeout_fe", fe_cnt, 1);
    check("timeout_pv", pv_cnt, 0);
    check("timeout_loc_hold", {10'b0, pat_location}, 0);
    clear_counts();
    send_frame(22'h0ABCDE);
    wait_clks(10);
    check("after_timeout_pv",  pv_cnt, 1);
    check("after_timeout_loc", {10'b0, pat_location}, 32'h0ABCDE);
    m_loc = 22'h0ABCDE;

    // Short low glitch on an idle line
    clear_counts();
    @(negedge clk);
    uart_rx = 1'b0;
    wait_clks(CPB / 4);
    uart_rx = 1'b1;
    wait_clks(20 * CPB);
    check("glitch_pv", pv_cnt, 0);
    check("glitch_fe", fe_cnt, 0);

    // Bad stop bit on B1, then a valid frame proves the FSM is hunting
    clear_counts();
    send_byte(HDR, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h44, 1'b0);
    wait_clks(10);
    check("stopbit_fe", fe_cnt, 1);
    check("stopbit_pv", pv_cnt, 0);
    clear_counts();
    send_frame(22'h06444C);
    wait_clks(10);
    check("after_stopbit_pv",  pv_cnt, 1);
    check("after_stopbit_fe",  fe_cnt, 0);
    check("after_stopbit_loc", {10'b0, pat_location}, 32'h06444C);

    // Reset for 1 clk after B1, then a full frame
    clear_counts();
    send_byte(HDR, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_loc",  {10'b0, pat_location}, 0);
    check("midreset_link", {31'b0, link_up}, 0);
    check("midreset_pv",   {31'b0, pat_valid}, 0);
    check("midreset_fe",   {31'b0, frame_err}, 0);
    wait_clks(5);
    clear_counts();
    send_frame(22'h2A5A5A);
    wait_clks(10);
    check("after_reset_pv",   pv_cnt, 1);
    check("after_reset_fe",   fe_cnt, 0);
    check("after_reset_loc",  {10'b0, pat_location}, 32'h2A5A5A);
    check("after_reset_link", {31'b0, link_up}, 1);
    m_loc  = 22'h2A5A5A;
    m_link = 1'b1;

    // Random frame streams against the model
    for (int t = 0; t < 25; t++) begin
      stream.delete();
      kind = $urandom_range(0, 3);
      rloc = 22'($urandom);
      b0 = {2'b00, rloc[21:16]};
      b1 = rloc[15:8];
      b2 = rloc[7:0];
      ck = b0 ^ b1 ^ b2;
      if (kind == 1) ck = ck ^ 8'($urandom_range(1, 255));
      if (kind == 2) b0[7:6] = 2'($urandom_range(1, 3));
      if (kind == 2) ck = b0 ^ b1 ^ b2;
      if (kind == 3) begin
        for (int j = 0; j < $urandom_range(1, 2); j++) begin
          logic [7:0] junk;
          junk = 8'($urandom);
          if (junk == HDR) junk = 8'h5A;
          stream.push_back(junk);
        end
      end
      stream.push_back(HDR);
      stream.push_back(b0);
      stream.push_back(b1);
      stream.push_back(b2);
      stream.push_back(ck);
      model_stream();
      clear_counts();
      for (int j = 0; j < stream.size(); j++) send_byte(stream[j], 1'b1);
      wait_clks(10);
      check($sformatf("rand%0d_pv", t),   pv_cnt, e_pv);
      check($sformatf("rand%0d_fe", t),   fe_cnt, e_fe);
      check($sformatf("rand%0d_loc", t),  {10'b0, pat_location}, {10'b0, m_loc});
      check($sformatf("rand%0d_link", t), {31'b0, link_up}, {31'b0, m_link});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pat_frame_rx.md
# pat_frame_rx

Serial front end that produces the 22-bit paddle location consumed by the motion engine. It receives UART frames from the 52-series MCU (accelerometer/bat sensor side) and validates header, reserved bits and checksum. It then presents a stable `pat_location` word plus a one-cycle `pat_valid` strobe and a `link_up` level that the top level uses as the motion engine's `start`. It sits between the board UART pin and the motion/VGA path, in the same clock domain as the motion engine.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: UART bit rate.
- `HEADER`, 8'hA5: frame sync byte.
- `TIMEOUT_CLKS`, 20*(CLK_FREQ/BAUD): maximum idle gap between bytes inside one frame.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `uart_rx` input 1: asynchronous serial line from the MCU, idles high.
- `pat_location` output 22: last accepted location, {x[10:0], y[10:0]}.
- `pat_valid` output 1: one-cycle pulse when `pat_location` has just been updated.
- `frame_err` output 1: one-cycle pulse on any rejected frame or byte.
- `link_up` output 1: set on first accepted frame; stays high until reset.

## Operation
- Wire format: 8N1, LSB first. Frame = HEADER, B0, B1, B2, CK.
- B0 = {2'b00, loc[21:16]}, B1 = loc[15:8], B2 = loc[7:0], CK = B0^B1^B2.
- Byte receiver (sub-module):
  - `uart_rx` passes through a 2-flop synchronizer.
  - Falling edge in IDLE starts a bit counter at CLKS_PER_BIT = CLK_FREQ/BAUD.
  - At the half-bit point the line must still be low, otherwise return to IDLE (glitch, no error).
  - The 8 data bits are sampled at successive bit centres, then the stop bit.
  - Stop bit 1: pulse `byte_valid` with `byte_data`. Stop bit 0: pulse `byte_ferr`.
  - The receiver then waits for line high before re-arming.
- Frame FSM states: HUNT, GET_B0, GET_B1, GET_B2, GET_CK.
  - HUNT: a byte equal to HEADER moves to GET_B0. Any other byte is dropped silently.
  - GET_B0, GET_B1, GET_B2: store the byte and advance.
  - GET_CK: the frame is accepted if CK matches and B0[7:6]==0.
    - Accepted: latch `pat_location`, pulse `pat_valid`, set `link_up`.
    - Rejected: pulse `frame_err` and leave `pat_location` unchanged.
    - Either way, return to HUNT.
- `byte_ferr` in any state: pulse `frame_err` and go to HUNT. In HUNT it pulses too.
- Timeout: in GET_* states a gap counter resets on each `byte_valid`. If it reaches TIMEOUT_CLKS, pulse `frame_err` and go to HUNT.
- No range clamping of x/y here; the motion engine owns screen limits.

## Timing
- Reset values:
  - `pat_location`=0, `pat_valid`=0, `frame_err`=0, `link_up`=0.
  - FSM in HUNT, receiver in IDLE, counters 0.
- Reset mid-frame discards all partial bytes and frame state; the next frame must begin with a fresh start bit.
- Latency:
  - `byte_valid` fires at the stop-bit centre, about 2 clk after the synchronizer sees that sample.
  - `pat_valid` and the new `pat_location` appear on the clk edge after CK's `byte_valid`.
- `pat_location` is held between updates. It changes only on the same cycle `pat_valid` rises.
- `pat_valid` and `frame_err` are never high together. Each is high for exactly 1 clk.
- Timeout and `byte_valid` in the same cycle: the byte wins and the gap counter clears.
- Counter widths are sized from the parameters: $clog2(CLKS_PER_BIT+1) and $clog2(TIMEOUT_CLKS+1).

## Structure
- Shared package `pingpong_pkg`: LOC_W=22, COORD_W=11, frame state enum, default HEADER.
- Sub-module `uart_byte_rx`: synchronizer, bit timing, shift register. Outputs `byte_valid`, `byte_data[7:0]`, `byte_ferr`.
- `pat_frame_rx` contains the frame FSM, checksum, timeout counter and output registers.

## Test plan
Bench drives `uart_rx` with a bit-accurate serializer; use BAUD=CLK_FREQ/16 for speed.
- Valid frame A5,06,44,4C,0E → one `pat_valid` pulse. `pat_location`=22'h06444C (x=200, y=1100). `link_up`=1.
- Same frame with CK=0F → `frame_err` pulse. `pat_location` stays 0 and `link_up` stays 0.
- Bytes 3C,A5 followed by a valid frame body → junk dropped silently, no `frame_err`, frame accepted.
- A5,06 then silence longer than TIMEOUT_CLKS → `frame_err` pulse. A following full valid frame is accepted.
- Low glitch of CLKS_PER_BIT/4 on an idle line → no byte and no error. Stop bit forced 0 on B1 → `frame_err`, FSM in HUNT.
- `rst_n` low for 1 clk after B1 of a frame, then a complete valid frame → only the second frame produces `pat_valid`, and outputs read reset values in between.
